// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions: stall-vector bit positions, datapath widths,
// the canonical NOP encoding and the fetch-stage state type.
package cpu_defs;

  localparam int unsigned STALL_PC = 0;
  localparam int unsigned STALL_IF = 1;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    IDLE,
    MISS
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache_array.sv
// Direct-mapped instruction cache storage: one 32-bit word per line.
// Combinational read port, synchronous write port; reset clears only the
// valid bits, so tag/data contents are don't-care until a line is written.
module icache_array
  import cpu_defs::*;
#(
  parameter int unsigned INDEX_LEN   = 7,
  parameter int unsigned ICACHE_SIZE = 128
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [INDEX_LEN-1:0]          rd_index,
  input  logic [ADDR_W-INDEX_LEN-3:0]   rd_tag,
  output logic                          rd_hit,
  output logic [INST_W-1:0]             rd_data,
  input  logic                          wr_en,
  input  logic [INDEX_LEN-1:0]          wr_index,
  input  logic [ADDR_W-INDEX_LEN-3:0]   wr_tag,
  input  logic [INST_W-1:0]             wr_data
);

  logic [ICACHE_SIZE-1:0]        valid_q;
  logic [ADDR_W-INDEX_LEN-3:0]   tag_q  [ICACHE_SIZE];
  logic [INST_W-1:0]             data_q [ICACHE_SIZE];

  // Valid bits: cleared on reset, set when a line is filled.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage; a fill overwrites whatever the line held.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  // Lookup: hit when the indexed line is valid and its tag matches.
  always_comb begin
    rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    rd_data = data_q[rd_index];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: looks up pc_in, fetches missed words from the
// memory controller and hands (pc, inst) pairs to decode.
// ICACHE_EN defined   : direct-mapped cache (icache_array).
// ICACHE_EN undefined : a single-entry buffer holding the last fetched word.
module inst_fetch
  import cpu_defs::*;
#(
  parameter int unsigned INDEX_LEN   = 7,
  parameter int unsigned ICACHE_SIZE = 128
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [5:0]        stall_in,
  input  logic              branch_or_not,
  input  logic              mem_done_in,
  input  logic [INST_W-1:0] mem_inst_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              if_stall_req_out,
  output logic              if_valid_out,
  output logic [ADDR_W-1:0] if_pc_out,
  output logic [INST_W-1:0] if_inst_out
);

  fetch_state_e      state_q, state_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d;
  logic [ADDR_W-1:0] pc_d;
  logic [INST_W-1:0] inst_d;

  logic              lk_hit;
  logic [INST_W-1:0] lk_data;
  logic              fill_en;

  // Bits of inputs/configuration with no role in the datapath.
  logic unused_bits;
  assign unused_bits = ^{pc_in[1:0], stall_in[5:2], stall_in[STALL_PC],
                         (ICACHE_SIZE != (32'd1 << INDEX_LEN))};

  // A fill lands only from MISS; a done pulse while frozen is not observed.
  assign fill_en = rdy_in && (state_q == MISS) && mem_done_in;

`ifdef ICACHE_EN
  logic [INDEX_LEN-1:0]        lk_index;
  logic [ADDR_W-INDEX_LEN-3:0] lk_tag;

  assign lk_index = pc_in[INDEX_LEN+1:2];
  assign lk_tag   = pc_in[ADDR_W-1:INDEX_LEN+2];

  // Fill address comes from the latched request, not pc_in, because a
  // redirect during MISS may already have moved pc_in elsewhere.
  icache_array #(
    .INDEX_LEN   (INDEX_LEN),
    .ICACHE_SIZE (ICACHE_SIZE)
  ) u_icache (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (lk_index),
    .rd_tag   (lk_tag),
    .rd_hit   (lk_hit),
    .rd_data  (lk_data),
    .wr_en    (fill_en),
    .wr_index (mem_addr_out[INDEX_LEN+1:2]),
    .wr_tag   (mem_addr_out[ADDR_W-1:INDEX_LEN+2]),
    .wr_data  (mem_inst_in)
  );
`else
  logic              buf_valid_q;
  logic [ADDR_W-3:0] buf_addr_q;
  logic [INST_W-1:0] buf_data_q;

  // One-entry buffer capturing the last returned word with its address.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (fill_en) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= mem_addr_out[ADDR_W-1:2];
      buf_data_q  <= mem_inst_in;
    end
  end

  // Buffer lookup by full word address.
  always_comb begin
    lk_hit  = buf_valid_q && (buf_addr_q == pc_in[ADDR_W-1:2]);
    lk_data = buf_data_q;
  end
`endif

  // Stall request: outstanding fetch, or current pc_in does not hit.
  always_comb begin
    if_stall_req_out = (state_q == MISS) || !lk_hit;
  end

  // State register; frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next state and next registered outputs; flush beats stall beats lookup.
  always_comb begin
    state_d = state_q;
    req_d   = mem_req_out;
    addr_d  = mem_addr_out;
    valid_d = if_valid_out;
    pc_d    = if_pc_out;
    inst_d  = if_inst_out;
    case (state_q)
      IDLE: begin
        if (branch_or_not) begin
          valid_d = 1'b0;
        end else if (!stall_in[STALL_IF]) begin
          if (lk_hit) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            inst_d  = lk_data;
          end else begin
            valid_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = {pc_in[ADDR_W-1:2], 2'b00};
            state_d = MISS;
          end
        end
      end
      MISS: begin
        // The request cannot be aborted: a flush only kills the output.
        if (branch_or_not) begin
          valid_d = 1'b0;
        end
        if (mem_done_in) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered memory-request and decode outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_req_out  <= 1'b0;
      mem_addr_out <= '0;
      if_valid_out <= 1'b0;
      if_pc_out    <= '0;
      if_inst_out  <= '0;
    end else if (rdy_in) begin
      mem_req_out  <= req_d;
      mem_addr_out <= addr_d;
      if_valid_out <= valid_d;
      if_pc_out    <= pc_d;
      if_inst_out  <= inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a PC-register/memory model drives the
// stage, expected (pc, inst) pairs are queued on acceptance and compared as
// decode outputs appear. Follows ICACHE_EN the same way as the design.
module tb_inst_fetch;
  import cpu_defs::*;

  localparam int unsigned L = 3;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] pc_in = '0;
  logic [5:0]  stall_in = 6'b000010;
  logic        branch_or_not = 1'b0;
  logic        mem_done_in = 1'b0;
  logic [31:0] mem_inst_in = '0;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        if_stall_req_out;
  logic        if_valid_out;
  logic [31:0] if_pc_out;
  logic [31:0] if_inst_out;

  inst_fetch #(.INDEX_LEN(7), .ICACHE_SIZE(128)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .pc_in            (pc_in),
    .stall_in         (stall_in),
    .branch_or_not    (branch_or_not),
    .mem_done_in      (mem_done_in),
    .mem_inst_in      (mem_inst_in),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .if_stall_req_out (if_stall_req_out),
    .if_valid_out     (if_valid_out),
    .if_pc_out        (if_pc_out),
    .if_inst_out      (if_inst_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return NOP_INST;
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // Reference lookup model
`ifdef ICACHE_EN
  bit          m_valid [128];
  logic [29:0] m_addr  [128];
  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[8:2]] && (m_addr[a[8:2]] == a[31:2]);
  endfunction
  task automatic model_fill(input logic [31:0] a);
    m_valid[a[8:2]] = 1'b1;
    m_addr[a[8:2]]  = a[31:2];
  endtask
  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask
`else
  bit          b_valid = 1'b0;
  logic [29:0] b_addr  = '0;
  function automatic bit model_hit(input logic [31:0] a);
    return b_valid && (b_addr == a[31:2]);
  endfunction
  task automatic model_fill(input logic [31:0] a);
    b_valid = 1'b1;
    b_addr  = a[31:2];
  endtask
  task automatic model_clear();
    b_valid = 1'b0;
  endtask
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic [31:0] stream[$];
  exp_t        exp_q[$];
  int unsigned deliv_cycle[$];

  bit          user_stall = 1'b0;
  bit          user_rdy   = 1'b1;
  bit          held_last  = 1'b0;
  bit          last_valid = 1'b0;
  exp_t        last_exp;
  bit          miss_prev  = 1'b0;
  bit          prev_req   = 1'b0;
  bit          done_next  = 1'b0;
  logic [31:0] exp_addr   = '0;
  int unsigned mem_cnt      = 0;
  int unsigned req_rises    = 0;
  int unsigned stall_cycles = 0;
  int unsigned cycle_no     = 0;
  int unsigned n_deliv      = 0;

  task automatic apply();
    if (stream.size() > 0) pc_in = stream[0];
    rdy_in   = user_rdy;
    stall_in = {4'b0000, (user_stall || (stream.size() == 0)), 1'b0};
  endtask

  // One clock: sample/check at negedge, update models at posedge, drive at +1.
  task automatic step();
    bit accepted, miss_start, held_next, fill_edge;
    exp_t e;
    @(negedge clk_in);
    cycle_no++;
    if (rst_in) begin
      mem_cnt = 0;
      miss_prev = 1'b0;
      last_valid = 1'b0;
      prev_req = 1'b0;
      exp_q.delete();
    end else begin
      if (held_last) begin
        check_eq("hold_valid", if_valid_out, last_valid);
        if (last_valid) begin
          check_eq("hold_pc", if_pc_out, last_exp.pc);
          check_eq("hold_inst", if_inst_out, last_exp.inst);
        end
      end else if (if_valid_out) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_output", if_valid_out, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_pc", if_pc_out, e.pc);
          check_eq("out_inst", if_inst_out, e.inst);
          last_exp = e;
          last_valid = 1'b1;
          n_deliv++;
          deliv_cycle.push_back(cycle_no);
        end
      end else begin
        last_valid = 1'b0;
      end
      if (miss_prev) begin
        check_eq("req_rise", mem_req_out, 32'd1);
        check_eq("req_addr", mem_addr_out, exp_addr);
      end
      if (mem_req_out && !prev_req) req_rises++;
      prev_req = mem_req_out;
      if (if_stall_req_out) stall_cycles++;
      if (mem_req_out) check_eq("stall_miss", if_stall_req_out, 32'd1);
      else             check_eq("stall_lookup", if_stall_req_out, {31'd0, !model_hit(pc_in)});
    end
    fill_edge  = !rst_in && rdy_in && mem_done_in;
    accepted   = !rst_in && rdy_in && !branch_or_not && !stall_in[1] && !if_stall_req_out;
    miss_start = !rst_in && rdy_in && !branch_or_not && !stall_in[1] && !mem_req_out && !model_hit(pc_in);
    held_next  = !rst_in && (!rdy_in || (stall_in[1] && !branch_or_not));
    if (accepted) exp_q.push_back('{pc_in, mem_word(pc_in)});
    if (miss_start) exp_addr = {pc_in[31:2], 2'b00};
    done_next = 1'b0;
    if (!rst_in && mem_req_out && rdy_in && !mem_done_in) begin
      mem_cnt++;
      if (mem_cnt >= L - 1 && user_rdy) begin
        done_next = 1'b1;
        mem_cnt = 0;
      end
    end
    @(posedge clk_in);
    held_last = held_next;
    miss_prev = miss_start;
    if (fill_edge) model_fill(exp_addr);
    if (rst_in) model_clear();
    #1;
    if (accepted) void'(stream.pop_front());
    mem_done_in   = done_next;
    mem_inst_in   = done_next ? mem_word(exp_addr) : 32'hDEAD_BEEF;
    branch_or_not = 1'b0;
    apply();
  endtask

  task automatic run_drain(input int unsigned max_cycles);
    int unsigned n = 0;
    while ((stream.size() > 0 || exp_q.size() > 0 || mem_req_out) && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("drain_left", stream.size() + exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    stream.delete();
    user_stall = 1'b0;
    user_rdy = 1'b1;
    rst_in = 1'b1;
    step();
    step();
    check_eq("rst_req", mem_req_out, 32'd0);
    check_eq("rst_addr", mem_addr_out, 32'd0);
    check_eq("rst_valid", if_valid_out, 32'd0);
    check_eq("rst_pc", if_pc_out, 32'd0);
    check_eq("rst_inst", if_inst_out, 32'd0);
    rst_in = 1'b0;
  endtask

  task automatic load(input logic [31:0] a[$]);
    stream = a;
    apply();
  endtask

  initial begin
    int unsigned base, s0, n0, r0, d0, n;
    #1;
    do_reset();

    // Cold start
    load('{32'h0});
    base = cycle_no; s0 = stall_cycles;
    run_drain(40);
    check_eq("cold_stall_cycles", stall_cycles - s0, L + 1);
    check_eq("cold_latency", deliv_cycle[$] - base - 1, L + 2);

    // Warm hits: preload then replay
    load('{32'h0, 32'h4, 32'h8, 32'hC});
    run_drain(100);
    load('{32'h0, 32'h4, 32'h8, 32'hC});
    base = cycle_no; s0 = stall_cycles; n0 = deliv_cycle.size();
    run_drain(100);
`ifdef ICACHE_EN
    check_eq("warm_first", deliv_cycle[n0] - base - 1, 32'd1);
    check_eq("warm_span", deliv_cycle[$] - deliv_cycle[n0], 32'd3);
    check_eq("warm_stall", stall_cycles - s0, 32'd0);
`else
    check_eq("warm_first", deliv_cycle[n0] - base - 1, L + 2);
    check_eq("warm_span", deliv_cycle[$] - deliv_cycle[n0], 3 * (L + 2));
    check_eq("warm_stall", stall_cycles - s0, 4 * (L + 1));
`endif

    // Flush during a miss on 0x40, redirect to 0x0
    load('{32'h40});
    n = 0;
    while (!mem_req_out && n < 10) begin step(); n++; end
    check_eq("flush_req_seen", mem_req_out, 32'd1);
    branch_or_not = 1'b1;
    load('{32'h0});
    d0 = n_deliv;
    run_drain(60);
    check_eq("flush_deliveries", n_deliv - d0, 32'd1);
    check_eq("flush_last_pc", last_exp.pc, 32'h0);
    r0 = req_rises;
    load('{32'h40});
    run_drain(60);
`ifdef ICACHE_EN
    check_eq("flush_fill_kept", req_rises - r0, 32'd0);
`else
    check_eq("flush_fill_kept", req_rises - r0, 32'd1);
`endif

    // Flush in IDLE on a missing pc: no request may start
    load('{32'h44});
    branch_or_not = 1'b1;
    step();
    r0 = req_rises;
    load('{32'h8});
    run_drain(60);
`ifdef ICACHE_EN
    check_eq("idle_flush_reqs", req_rises - r0, 32'd0);
`else
    check_eq("idle_flush_reqs", req_rises - r0, 32'd1);
`endif

    // Same-index conflict: 0x200 evicts 0x0
    r0 = req_rises;
    load('{32'h200, 32'h0});
    run_drain(60);
    check_eq("conflict_reqs", req_rises - r0, 32'd2);

    // Stall and ready freezes mid-stream
    d0 = n_deliv;
    load('{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14});
    repeat (3) step();
    user_stall = 1'b1; apply();
    repeat (3) step();
    user_stall = 1'b0; apply();
    repeat (2) step();
    user_rdy = 1'b0; apply();
    repeat (3) step();
    user_rdy = 1'b1; apply();
    run_drain(150);
    check_eq("stall_rdy_deliveries", n_deliv - d0, 32'd6);

    // Reset while a miss is outstanding
    load('{32'h80});
    n = 0;
    while (!mem_req_out && n < 10) begin step(); n++; end
    check_eq("rstmiss_req_seen", mem_req_out, 32'd1);
    do_reset();
    r0 = req_rises;
    load('{32'hC});
    run_drain(60);
    check_eq("rstmiss_refetch", req_rises - r0, 32'd1);

    check_eq("final_queue", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
